// File: rtl/led_code_gen.sv
// Status-code LED sequencer: blinks the pending code N times per repetition,
// separated by a dark gap, and stretches data-activity strobes while idle.
module led_code_gen #(
  parameter int FREQ      = 100000000,
  parameter int TICK_HZ   = 10,
  parameter int GAP_TICKS = 10,
  parameter int ACT_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code_in,
  input  logic       code_valid,
  input  logic       act_pulse,
  output logic       en,
  output logic       busy,
  output logic [3:0] cur_code
);

  localparam int PERIOD = FREQ / TICK_HZ;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int GW     = $clog2(GAP_TICKS + 1);
  localparam int AW     = $clog2(ACT_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    pending;
  logic [3:0]    pulse_cnt, pulse_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [AW-1:0] act_cnt, act_d;
  logic [3:0]    cur_d;
  logic          act_ok;
  logic          en_d, busy_d;

  assign tick = (presc == PW'(PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Pending is a mailbox: a write mid-sequence only takes effect at the next IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 4'd0;
    end else if (code_valid) begin
      pending <= code_in;
    end
  end

  // A simultaneous non-zero code write outranks an activity strobe.
  assign act_ok = (state == IDLE) && (pending == 4'd0) &&
                  !(code_valid && (code_in != 4'd0));

  always_comb begin
    state_d = state;
    pulse_d = pulse_cnt;
    gap_d   = gap_cnt;
    act_d   = act_cnt;
    cur_d   = cur_code;
    case (state)
      IDLE: begin
        if (act_ok && act_pulse) begin
          act_d = AW'(ACT_TICKS);
        end else if (tick && (act_cnt != '0)) begin
          act_d = act_cnt - AW'(1);
        end
        if (tick && (pending != 4'd0)) begin
          state_d = ON;
          cur_d   = pending;
          pulse_d = pending;
          act_d   = '0;
        end
      end
      ON: begin
        if (tick) begin
          pulse_d = pulse_cnt - 4'd1;
          state_d = OFF;
        end
      end
      OFF: begin
        if (tick) begin
          if (pulse_cnt != 4'd0) begin
            state_d = ON;
          end else begin
            gap_d   = GW'(GAP_TICKS);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt <= GW'(1)) begin
            gap_d   = '0;
            cur_d   = 4'd0;
            state_d = IDLE;
          end else begin
            gap_d = gap_cnt - GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are derived from next-state values so they register in step with the FSM.
    en_d   = (state_d == ON) || ((state_d == IDLE) && (act_d != '0));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pulse_cnt <= 4'd0;
      gap_cnt   <= '0;
      act_cnt   <= '0;
      cur_code  <= 4'd0;
      en        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      pulse_cnt <= pulse_d;
      gap_cnt   <= gap_d;
      act_cnt   <= act_d;
      cur_code  <= cur_d;
      en        <= en_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_led_code_gen.sv
// Directed bench for led_code_gen: tick every 10 cycles, 3 gap ticks, 2 activity ticks.
module tb_led_code_gen;

  logic       clk;
  logic       rst;
  logic [3:0] code_in;
  logic       code_valid;
  logic       act_pulse;
  logic       en;
  logic       busy;
  logic [3:0] cur_code;

  int totalEdges;
  int baseEdge;
  int checks;
  int passes;
  int highCount;

  led_code_gen #(
    .FREQ(100),
    .TICK_HZ(10),
    .GAP_TICKS(3),
    .ACT_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .code_in(code_in),
    .code_valid(code_valid),
    .act_pulse(act_pulse),
    .en(en),
    .busy(busy),
    .cur_code(cur_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial totalEdges = 0;
  always @(posedge clk) totalEdges = totalEdges + 1;

  // Edge numbers are counted from the last reset release; returns 1 ns after edge e.
  task automatic gotoEdge(input int e);
    while ((totalEdges - baseEdge) < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks = checks + 1;
    if (observed === expected) begin
      passes = passes + 1;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected,
               totalEdges - baseEdge);
    end
  endtask

  // Drives a one-cycle strobe; the DUT samples it at edge atEdge+1.
  task automatic applyStimulus(input int atEdge, input logic cv, input logic [3:0] code,
                               input logic act);
    gotoEdge(atEdge);
    code_valid = cv;
    code_in    = code;
    act_pulse  = act;
    gotoEdge(atEdge + 1);
    code_valid = 1'b0;
    code_in    = 4'd0;
    act_pulse  = 1'b0;
  endtask

  task automatic countHigh(input int first, input int samples);
    highCount = 0;
    for (int k = 0; k < samples; k++) begin
      gotoEdge(first + 10 * k);
      if (en === 1'b1) highCount = highCount + 1;
    end
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    baseEdge   = 0;
    rst        = 1'b1;
    code_in    = 4'd0;
    code_valid = 1'b0;
    act_pulse  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset en", 8'(en), 8'd0);
    checkOutput("reset busy", 8'(busy), 8'd0);
    checkOutput("reset cur_code", 8'(cur_code), 8'd0);
    rst      = 1'b0;
    baseEdge = totalEdges;

    // Code 3 from IDLE
    applyStimulus(2, 1'b1, 4'd3, 1'b0);
    gotoEdge(9);
    checkOutput("pre-tick en", 8'(en), 8'd0);
    checkOutput("pre-tick busy", 8'(busy), 8'd0);
    gotoEdge(10);
    checkOutput("first ON en", 8'(en), 8'd1);
    checkOutput("first ON busy", 8'(busy), 8'd1);
    checkOutput("first ON cur_code", 8'(cur_code), 8'd3);
    gotoEdge(20);
    checkOutput("first OFF en", 8'(en), 8'd0);
    checkOutput("first OFF busy", 8'(busy), 8'd1);
    countHigh(25, 8);
    checkOutput("code3 remaining pulses", 8'(highCount), 8'd2);
    gotoEdge(99);
    checkOutput("gap end busy", 8'(busy), 8'd1);
    checkOutput("gap end cur_code", 8'(cur_code), 8'd3);
    gotoEdge(100);
    checkOutput("idle busy", 8'(busy), 8'd0);
    checkOutput("idle cur_code", 8'(cur_code), 8'd0);
    checkOutput("idle en", 8'(en), 8'd0);
    gotoEdge(110);
    checkOutput("repeat en", 8'(en), 8'd1);
    checkOutput("repeat cur_code", 8'(cur_code), 8'd3);

    // Code 2 written while code 3 is running
    applyStimulus(112, 1'b1, 4'd2, 1'b0);
    gotoEdge(150);
    checkOutput("third pulse en", 8'(en), 8'd1);
    checkOutput("third pulse cur_code", 8'(cur_code), 8'd3);
    gotoEdge(170);
    checkOutput("gap2 en", 8'(en), 8'd0);
    checkOutput("gap2 busy", 8'(busy), 8'd1);
    gotoEdge(200);
    checkOutput("idle2 busy", 8'(busy), 8'd0);
    gotoEdge(210);
    checkOutput("code2 start en", 8'(en), 8'd1);
    checkOutput("code2 cur_code", 8'(cur_code), 8'd2);
    countHigh(215, 7);
    checkOutput("code2 pulse count", 8'(highCount), 8'd2);
    gotoEdge(280);
    checkOutput("idle3 busy", 8'(busy), 8'd0);

    // Code 0 during ON stops after this sequence's gap
    applyStimulus(292, 1'b1, 4'd0, 1'b0);
    gotoEdge(310);
    checkOutput("stop seq en", 8'(en), 8'd1);
    checkOutput("stop seq cur_code", 8'(cur_code), 8'd2);
    gotoEdge(359);
    checkOutput("stop gap busy", 8'(busy), 8'd1);
    gotoEdge(360);
    checkOutput("stopped busy", 8'(busy), 8'd0);
    checkOutput("stopped cur_code", 8'(cur_code), 8'd0);
    gotoEdge(400);
    checkOutput("stopped en", 8'(en), 8'd0);
    checkOutput("stopped busy late", 8'(busy), 8'd0);

    // Activity stretch with retrigger 15 cycles later
    applyStimulus(422, 1'b0, 4'd0, 1'b1);
    checkOutput("act en", 8'(en), 8'd1);
    checkOutput("act busy", 8'(busy), 8'd0);
    gotoEdge(430);
    checkOutput("act after 1 tick", 8'(en), 8'd1);
    applyStimulus(437, 1'b0, 4'd0, 1'b1);
    gotoEdge(440);
    checkOutput("act retrigger held", 8'(en), 8'd1);
    gotoEdge(449);
    checkOutput("act before expiry", 8'(en), 8'd1);
    gotoEdge(450);
    checkOutput("act expired", 8'(en), 8'd0);

    // Code 4 and act_pulse together: code wins
    applyStimulus(462, 1'b1, 4'd4, 1'b1);
    checkOutput("priority en", 8'(en), 8'd0);
    gotoEdge(469);
    checkOutput("priority no stretch", 8'(en), 8'd0);
    gotoEdge(470);
    checkOutput("code4 start en", 8'(en), 8'd1);
    checkOutput("code4 cur_code", 8'(cur_code), 8'd4);
    gotoEdge(475);
    checkOutput("code4 first pulse", 8'(en), 8'd1);
    applyStimulus(482, 1'b1, 4'd5, 1'b0);
    countHigh(485, 10);
    checkOutput("code4 remaining pulses", 8'(highCount), 8'd3);
    gotoEdge(580);
    checkOutput("code4 done busy", 8'(busy), 8'd0);
    gotoEdge(590);
    checkOutput("code5 start cur_code", 8'(cur_code), 8'd5);
    gotoEdge(611);
    checkOutput("code5 second ON en", 8'(en), 8'd1);
    checkOutput("code5 second ON busy", 8'(busy), 8'd1);

    // Asynchronous reset mid-sequence
    gotoEdge(612);
    rst = 1'b1;
    #1;
    checkOutput("async rst en", 8'(en), 8'd0);
    checkOutput("async rst busy", 8'(busy), 8'd0);
    checkOutput("async rst cur_code", 8'(cur_code), 8'd0);
    #2;
    rst      = 1'b0;
    baseEdge = totalEdges;
    gotoEdge(15);
    checkOutput("post rst busy", 8'(busy), 8'd0);
    checkOutput("post rst en", 8'(en), 8'd0);
    gotoEdge(60);
    checkOutput("post rst idle busy", 8'(busy), 8'd0);
    checkOutput("post rst idle en", 8'(en), 8'd0);
    checkOutput("post rst idle cur_code", 8'(cur_code), 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
